// File: rtl/comp_bist_pkg.sv
// Shared definitions for the 2-bit comparator BIST controller and its golden model.
package comp_bist_pkg;

    localparam int NUM_VEC = 32;
    localparam int IDX_W   = 5;
    localparam int ERR_W   = 6;
    localparam int CNT_W   = 4;

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_VEC - 1);
    localparam logic [IDX_W-1:0] FF_NONE   = '1;
    localparam logic [ERR_W-1:0] ERR_MAX   = ERR_W'(NUM_VEC);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_APPLY = 3'd1,
        ST_WAIT  = 3'd2,
        ST_CHECK = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Response bundle ordering used everywhere: {lt, eq, gt}.
    function automatic logic [2:0] pack_resp(input logic lt, input logic eq, input logic gt);
        return {lt, eq, gt};
    endfunction

endpackage

// File: rtl/comp2_golden.sv
// Reference 2-bit unsigned comparator with enable; outputs all low when disabled.
module comp2_golden (
    input  logic [1:0] a,
    input  logic [1:0] b,
    input  logic       e,
    output logic       lt,
    output logic       eq,
    output logic       gt
);

    // Gated unsigned compare.
    always_comb begin
        lt = e & (a < b);
        eq = e & (a == b);
        gt = e & (a > b);
    end

endmodule

// File: rtl/comp_bist.sv
// Exhaustive self-test sequencer for an external 2-bit comparator.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start after reset
// APPLY | drive vector idx onto a_out/b_out/e_out, load settle counter
// WAIT  | settle counter running down before the response is sampled
// CHECK | compare response against golden, log errors, advance idx
// DONE  | run complete; result held until next start or reset
module comp_bist
    import comp_bist_pkg::*;
#(
    parameter int SETTLE = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic [1:0] a_out,
    output logic [1:0] b_out,
    output logic       e_out,
    input  logic       lt_in,
    input  logic       eq_in,
    input  logic       gt_in,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [5:0] err_cnt,
    output logic [4:0] first_fail,
    output logic       no_fail
);

    localparam logic [CNT_W-1:0] SETTLE_L = CNT_W'(SETTLE);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         a_q, a_d;
    logic [1:0]         b_q, b_d;
    logic               e_q, e_d;
    logic [ERR_W-1:0]   err_q, err_d;
    logic [IDX_W-1:0]   ff_q, ff_d;
    logic               nf_q, nf_d;

    logic               exp_lt, exp_eq, exp_gt;
    logic               mismatch;

    // Golden response for the vector currently on the comparator inputs.
    comp2_golden u_golden (
        .a  (a_q),
        .b  (b_q),
        .e  (e_q),
        .lt (exp_lt),
        .eq (exp_eq),
        .gt (exp_gt)
    );

    // Any deviation, including multi-hot or all-zero patterns, is an error.
    always_comb begin
        mismatch = pack_resp(lt_in, eq_in, gt_in) != pack_resp(exp_lt, exp_eq, exp_gt);
    end

    // Next-state, vector and result bookkeeping.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        e_d     = e_q;
        err_d   = err_q;
        ff_d    = ff_q;
        nf_d    = nf_q;

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    err_d   = '0;
                    ff_d    = FF_NONE;
                    nf_d    = 1'b1;
                    idx_d   = '0;
                    state_d = ST_APPLY;
                end
            end
            ST_APPLY: begin
                e_d   = idx_q[4];
                a_d   = idx_q[3:2];
                b_d   = idx_q[1:0];
                cnt_d = SETTLE_L;
                if (SETTLE_L != '0) begin
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_CHECK;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 1'b1;
                // <= 1 rather than == 1 so a corrupted counter cannot stall the run.
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (mismatch) begin
                    if (err_q != ERR_MAX) begin
                        err_d = err_q + 1'b1;
                    end
                    if (nf_q) begin
                        ff_d = idx_q;
                        nf_d = 1'b0;
                    end
                end
                if (idx_q == LAST_IDX) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = ST_APPLY;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any run in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            e_q     <= 1'b0;
            err_q   <= '0;
            ff_q    <= FF_NONE;
            nf_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            e_q     <= e_d;
            err_q   <= err_d;
            ff_q    <= ff_d;
            nf_q    <= nf_d;
        end
    end

    // Status outputs decoded straight from registered state.
    always_comb begin
        busy       = (state_q == ST_APPLY) || (state_q == ST_WAIT) || (state_q == ST_CHECK);
        done       = (state_q == ST_DONE);
        pass       = done && (err_q == '0);
        a_out      = a_q;
        b_out      = b_q;
        e_out      = e_q;
        err_cnt    = err_q;
        first_fail = ff_q;
        no_fail    = nf_q;
    end

endmodule

// File: tb/tb_comp_bist.sv
// Bench for comp_bist: two instances (SETTLE=1 and SETTLE=0) each driving a
// behavioural comparator with selectable faults.
module tb_comp_bist;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic start1, start0;
    int   mode;
    logic sel0;

    logic [1:0] a1, b1, a0, b0;
    logic       e1, e0;
    logic       busy1, done1, pass1, nf1, busy0, done0, pass0, nf0;
    logic [5:0] err1, err0;
    logic [4:0] ff1, ff0;
    logic [2:0] r1, r0;

    // Comparator models. mode 0: correct, 1: eq stuck 0, 2: lt/gt ignore e,
    // 3: all three high when equal, 4: lt/gt swapped.
    function automatic logic [2:0] cmp_model(input int m, input logic e, input logic [1:0] a, input logic [1:0] b);
        logic l, q, g;
        l = (a < b);
        q = (a == b);
        g = (a > b);
        case (m)
            1:       return e ? {l, 1'b0, g} : 3'b000;
            2:       return {l, e & q, g};
            3:       return e ? (q ? 3'b111 : {l, q, g}) : 3'b000;
            4:       return e ? {g, q, l} : 3'b000;
            default: return e ? {l, q, g} : 3'b000;
        endcase
    endfunction

    always_comb r1 = cmp_model(mode, e1, a1, b1);
    always_comb r0 = cmp_model(mode, e0, a0, b0);

    comp_bist #(.SETTLE(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start1),
        .a_out(a1), .b_out(b1), .e_out(e1),
        .lt_in(r1[2]), .eq_in(r1[1]), .gt_in(r1[0]),
        .busy(busy1), .done(done1), .pass(pass1),
        .err_cnt(err1), .first_fail(ff1), .no_fail(nf1)
    );

    comp_bist #(.SETTLE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0),
        .a_out(a0), .b_out(b0), .e_out(e0),
        .lt_in(r0[2]), .eq_in(r0[1]), .gt_in(r0[0]),
        .busy(busy0), .done(done0), .pass(pass0),
        .err_cnt(err0), .first_fail(ff0), .no_fail(nf0)
    );

    logic       s_busy, s_done, s_pass, s_nf, s_e;
    logic [1:0] s_a, s_b;
    logic [5:0] s_err;
    logic [4:0] s_ff;

    always_comb begin
        if (sel0) begin
            s_busy = busy0; s_done = done0; s_pass = pass0; s_nf = nf0;
            s_e = e0; s_a = a0; s_b = b0; s_err = err0; s_ff = ff0;
        end else begin
            s_busy = busy1; s_done = done1; s_pass = pass1; s_nf = nf1;
            s_e = e1; s_a = a1; s_b = b1; s_err = err1; s_ff = ff1;
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        int         mode;
        bit         s0;
        int         restart_at;
        logic [5:0] err;
        logic [4:0] ff;
        logic       pass;
        logic       nf;
        int         cycles;
    } vec_t;

    typedef struct {
        logic [5:0] err;
        logic [4:0] ff;
        logic       pass;
        logic       nf;
        int         cycles;
    } exp_t;

    exp_t sb_q[$];

    task automatic chk_reset_dut(input string tag);
        chk({tag, "_a"},     32'(a1),    0);
        chk({tag, "_b"},     32'(b1),    0);
        chk({tag, "_e"},     32'(e1),    0);
        chk({tag, "_busy"},  32'(busy1), 0);
        chk({tag, "_done"},  32'(done1), 0);
        chk({tag, "_pass"},  32'(pass1), 0);
        chk({tag, "_err"},   32'(err1),  0);
        chk({tag, "_ff"},    32'(ff1),   32'h1F);
        chk({tag, "_nf"},    32'(nf1),   1);
    endtask

    task automatic run_case(input vec_t v);
        exp_t       ex;
        int         cyc;
        logic [4:0] prev, cur, nxt;
        sel0 = v.s0;
        mode = v.mode;
        #1;
        prev = {s_e, s_a, s_b};
        @(negedge clk);
        if (v.s0) start0 = 1'b1; else start1 = 1'b1;
        sb_q.push_back('{v.err, v.ff, v.pass, v.nf, v.cycles});
        @(posedge clk);
        #1;
        start0 = 1'b0;
        start1 = 1'b0;
        chk("start_busy", 32'(s_busy), 1);
        chk("start_done", 32'(s_done), 0);
        chk("start_err_clr", 32'(s_err), 0);
        chk("start_nf_set", 32'(s_nf), 1);
        chk("start_ff_set", 32'(s_ff), 32'h1F);
        cyc = 0;
        while (!s_done && cyc < v.cycles + 20) begin
            @(posedge clk);
            cyc++;
            #1;
            if (v.restart_at != 0 && cyc == v.restart_at) begin
                if (v.s0) start0 = 1'b1; else start1 = 1'b1;
            end else begin
                start0 = 1'b0;
                start1 = 1'b0;
            end
            cur = {s_e, s_a, s_b};
            if (cur != prev) begin
                nxt = prev + 5'd1;
                chk("vec_order", 32'(cur), 32'(nxt));
                prev = cur;
            end
        end
        start0 = 1'b0;
        start1 = 1'b0;
        ex = sb_q.pop_front();
        if (!s_done) begin
            n_checks++;
            n_fail++;
            $display("FAIL done_timeout: done not seen within %0d cycles, expected at %0d", cyc, ex.cycles);
        end
        chk("done_cycles", 32'(cyc), 32'(ex.cycles));
        chk("err_cnt", 32'(s_err), 32'(ex.err));
        chk("first_fail", 32'(s_ff), 32'(ex.ff));
        chk("pass", 32'(s_pass), 32'(ex.pass));
        chk("no_fail", 32'(s_nf), 32'(ex.nf));
        chk("done_busy", 32'(s_busy), 0);
        chk("hold_vec", 32'({s_e, s_a, s_b}), 32'h1F);
        repeat (2) @(posedge clk);
        #1;
        chk("done_held", 32'(s_done), 1);
    endtask

    vec_t tbl[8];

    initial begin
        tbl[0] = '{0, 1'b0, 0,  6'd0,  5'h1F, 1'b1, 1'b1, 96};
        tbl[1] = '{1, 1'b0, 0,  6'd4,  5'd16, 1'b0, 1'b0, 96};
        tbl[2] = '{2, 1'b0, 0,  6'd12, 5'd1,  1'b0, 1'b0, 96};
        tbl[3] = '{3, 1'b0, 0,  6'd4,  5'd16, 1'b0, 1'b0, 96};
        tbl[4] = '{4, 1'b0, 0,  6'd12, 5'd17, 1'b0, 1'b0, 96};
        tbl[5] = '{0, 1'b0, 20, 6'd0,  5'h1F, 1'b1, 1'b1, 96};
        tbl[6] = '{0, 1'b1, 0,  6'd0,  5'h1F, 1'b1, 1'b1, 64};
        tbl[7] = '{2, 1'b1, 0,  6'd12, 5'd1,  1'b0, 1'b0, 64};

        rst_n  = 1'b0;
        start1 = 1'b0;
        start0 = 1'b0;
        mode   = 0;
        sel0   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_dut("rst");
        chk("rst_busy0", 32'(busy0), 0);
        chk("rst_ff0", 32'(ff0), 32'h1F);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("idle_done", 32'(done1), 0);

        for (int i = 0; i < 8; i++) begin
            run_case(tbl[i]);
        end

        // Reset part-way through a failing run, then a clean full run.
        sel0 = 1'b0;
        mode = 2;
        @(negedge clk);
        start1 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        chk("pre_rst_errs", 32'(err1 != 6'd0), 1);
        chk("pre_rst_busy", 32'(busy1), 1);
        rst_n = 1'b0;
        #1;
        chk_reset_dut("midrst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("post_rst_idle", 32'(busy1), 0);
        run_case('{0, 1'b0, 0, 6'd0, 5'h1F, 1'b1, 1'b1, 96});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish, limit 200000 expected earlier");
        $fatal(1);
    end

endmodule

// File: doc/comp_bist.md
COMP_BIST -- requirements
Module: comp_bist

Interface
REQ-001 SHALL have parameter: SETTLE, 1, idle cycles between driving a vector and sampling the response (legal 0..15).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: start  input  1  one-cycle request to run the exhaustive test.
REQ-005 SHALL have port: a_out  output  2  operand A driven to the comparator under test.
REQ-006 SHALL have port: b_out  output  2  operand B driven to the comparator under test.
REQ-007 SHALL have port: e_out  output  1  enable driven to the comparator under test.
REQ-008 SHALL have port: lt_in, eq_in, gt_in  input  1 each  comparator responses.
REQ-009 SHALL have port: busy  output  1  high while a test run is in progress.
REQ-010 SHALL have port: done  output  1  high once a run has completed, until the next start or reset.
REQ-011 SHALL have port: pass  output  1  valid while done; 1 iff err_cnt==0.
REQ-012 SHALL have port: err_cnt  output  6  count of mismatching vectors in the current or last run.
REQ-013 SHALL have port: first_fail  output  5  index of the first mismatching vector; 5'h1F with no_fail=1 when none.
REQ-014 SHALL have port: no_fail  output  1  high when no mismatch has yet been recorded in the run.

Function
REQ-015 SHALL apply 32 vectors, index idx 0..31 in ascending order: e=idx[4], a=idx[3:2], b=idx[1:0].
REQ-016 SHALL compute expected response: e=0 -> lt=eq=gt=0; e=1 -> lt=(a<b), eq=(a==b), gt=(a>b), unsigned.
REQ-017 SHALL implement FSM states IDLE, APPLY, WAIT, CHECK, DONE.
REQ-018 IDLE/DONE: start=1 -> clear err_cnt, set first_fail=5'h1F and no_fail=1, idx=0, go APPLY; done cleared.
REQ-019 APPLY: register a_out/b_out/e_out from idx; load wait counter with SETTLE; go WAIT if SETTLE>0, else CHECK.
REQ-020 WAIT: decrement counter each cycle; go CHECK on the cycle the counter reaches 1.
REQ-021 CHECK: compare {lt_in,eq_in,gt_in} with expected; on mismatch increment err_cnt; on first mismatch set first_fail=idx and no_fail=0.
REQ-022 CHECK: idx==31 -> go DONE; otherwise idx+1 -> go APPLY.
REQ-023 Any X-free pattern other than the expected one, including multi-hot patterns, SHALL count as a mismatch.
REQ-024 SHALL assert done, with pass valid, exactly 32*(SETTLE+2) cycles after the edge that samples start.
REQ-025 busy SHALL be high in APPLY, WAIT and CHECK, and low in IDLE and DONE.
REQ-026 start SHALL be ignored while busy; start in DONE SHALL restart the run.
REQ-027 a_out/b_out/e_out SHALL hold their last value in DONE; err_cnt SHALL never wrap (maximum 32).

Reset
REQ-028 rst_n low SHALL asynchronously force: state IDLE, a_out=0, b_out=0, e_out=0, busy=0, done=0, pass=0, err_cnt=0, first_fail=5'h1F, no_fail=1, idx=0, wait counter 0.
REQ-029 Reset mid-run SHALL abort the run with no partial result retained; operation resumes on the first start after release.

Structure
REQ-030 A shared package SHALL hold the state enum, NUM_VEC=32, IDX_W=5 and ERR_W=6.
REQ-031 The expected-response logic SHALL be a combinational sub-module comp2_golden (a, b, e -> lt, eq, gt), reusable by benches.

Verification
REQ-032 Correct comparator, SETTLE=1, start pulse -> done after 96 cycles, pass=1, err_cnt=0, no_fail=1.
REQ-033 Comparator with eq stuck at 0 -> err_cnt=4, first_fail=16, pass=0.
REQ-034 Comparator ignoring e (active when e=0) -> err_cnt=12, first_fail=1, pass=0.
REQ-035 SETTLE=0, correct comparator -> done after 64 cycles, pass=1.
REQ-036 rst_n pulsed low at cycle 40 of a run -> all outputs at reset values immediately; a new start gives a full 96-cycle run.
REQ-037 start re-pulsed while busy -> no effect, done timing unchanged; start in DONE -> counters cleared, new run begins.
